// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: opcode constants, state and op-class enumerations, and AluOp bit indices
package control_sequencer_pkg;
  localparam int ALU_W = 13;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SHR = 5'd2, OP_SHRA = 5'd3, OP_SHL = 5'd4;
  localparam logic [4:0] OP_ROR = 5'd5, OP_ROL = 5'd6, OP_AND = 5'd7, OP_OR = 5'd8, OP_MUL = 5'd9;
  localparam logic [4:0] OP_DIV = 5'd10, OP_NEG = 5'd11, OP_NOT = 5'd12;
  localparam int ALU_ADD = 12, ALU_SUB = 11, ALU_SHR = 10, ALU_SHRA = 9, ALU_SHL = 8, ALU_ROR = 7;
  localparam int ALU_ROL = 6, ALU_AND = 5, ALU_OR = 4, ALU_MUL = 3, ALU_DIV = 2, ALU_NEG = 1, ALU_NOT = 0;
  typedef enum logic [2:0] {S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
  typedef enum logic [1:0] {C_TWO_OP, C_ONE_OP, C_MULDIV, C_ILLEGAL} op_class_t;
  // Opcodes run ADD..NOT in the same order as the AluOp bits, MSB first
  function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] opcode);
    return opcode <= OP_NOT ? ALU_W'(1) << (5'(ALU_ADD) - opcode) : '0;
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: run/IR/memory inputs and datapath control strobes between sequencer and datapath
interface control_sequencer_if #(parameter int NUM_REGS = 16);
  logic Run, MemReady;
  logic [31:0] IR;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic [control_sequencer_pkg::ALU_W-1:0] AluOp;
  logic Done, Illegal, MemTimeout;
  modport master (
    input Run, MemReady, IR,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, PCin, MARin, MDRin, IRin, Yin, Zin,
    output HIin, LOin, IncPC, Read, Rin, Rout, AluOp, Done, Illegal, MemTimeout
  );
  modport slave (
    output Run, MemReady, IR,
    input PCout, MDRout, Zhighout, Zlowout, HIout, LOout, PCin, MARin, MDRin, IRin, Yin, Zin,
    input HIin, LOin, IncPC, Read, Rin, Rout, AluOp, Done, Illegal, MemTimeout
  );
endinterface

// File: rtl/control_sequencer_instr_decoder.sv
// instr_decoder: maps an opcode to its execution class and one-hot AluOp vector
module instr_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0]       opcode,
  output op_class_t        op_class,
  output logic [ALU_W-1:0] alu_op
);
  always_comb begin
    op_class = opcode > OP_NOT ? C_ILLEGAL
             : (opcode == OP_MUL || opcode == OP_DIV) ? C_MULDIV
             : (opcode == OP_NEG || opcode == OP_NOT) ? C_ONE_OP : C_TWO_OP;
    alu_op = alu_onehot(opcode);
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: eight-state fetch/execute sequencer driving datapath bus enables and load strobes
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int NUM_REGS = 16
) (
  input logic Clock,
  input logic Clear,
  control_sequencer_if.master bus
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  state_t state, nxt, boundary;
  op_class_t op_class;
  logic [ALU_W-1:0] alu_op;
  logic [NUM_REGS-1:0] sel_a, sel_b, sel_c;
  logic [CW-1:0] wait_cnt;
  logic mem_timeout, t1_stall, unused_ir;
  instr_decoder u_dec (.opcode(bus.IR[31:27]), .op_class(op_class), .alu_op(alu_op));
  assign sel_a = NUM_REGS'(1) << bus.IR[26:23];
  assign sel_b = NUM_REGS'(1) << bus.IR[22:19];
  assign sel_c = NUM_REGS'(1) << bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];
  assign t1_stall = state == S_T1 && !bus.MemReady;
  assign boundary = bus.Run ? S_T0 : S_HALT;
  assign bus.MemTimeout = mem_timeout;
  // wait_cnt counts consecutive stalled T1 cycles; zero also marks the first T1 cycle for PCin
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= S_HALT;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= nxt;
      wait_cnt <= !t1_stall ? '0 : wait_cnt == CW'(MEM_WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      if (t1_stall && wait_cnt == CW'(MEM_WAIT_MAX - 1)) mem_timeout <= 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
    bus.HIout = 1'b0; bus.LOout = 1'b0; bus.PCin = 1'b0; bus.MARin = 1'b0;
    bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0;
    bus.HIin = 1'b0; bus.LOin = 1'b0; bus.IncPC = 1'b0; bus.Read = 1'b0;
    bus.Done = 1'b0; bus.Illegal = 1'b0;
    bus.Rin = '0; bus.Rout = '0; bus.AluOp = '0;
    case (state)
      S_HALT: nxt = bus.Run ? S_T0 : S_HALT;
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        nxt = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = wait_cnt == '0; bus.Read = 1'b1; bus.MDRin = 1'b1;
        nxt = bus.MemReady ? S_T2 : S_T1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        nxt = S_T3;
      end
      S_T3: begin
        bus.Illegal = op_class == C_ILLEGAL;
        bus.Rout = op_class == C_ILLEGAL ? '0 : sel_b;
        bus.Yin = op_class == C_TWO_OP || op_class == C_MULDIV;
        bus.Zin = op_class == C_ONE_OP;
        bus.AluOp = op_class == C_ONE_OP ? alu_op : '0;
        nxt = op_class == C_ILLEGAL ? boundary : op_class == C_ONE_OP ? S_T5 : S_T4;
      end
      S_T4: begin
        bus.Rout = sel_c; bus.AluOp = alu_op; bus.Zin = 1'b1;
        nxt = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        bus.LOin = op_class == C_MULDIV;
        bus.Rin = op_class == C_MULDIV ? '0 : sel_a;
        bus.Done = op_class != C_MULDIV;
        nxt = op_class == C_MULDIV ? S_T6 : boundary;
      end
      S_T6: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1; bus.Done = 1'b1;
        nxt = boundary;
      end
      default: nxt = S_HALT;
    endcase
  end
endmodule
